// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache view; master is the ifetch + memory controller view.
interface icache_if;
    logic [31:0] IC_addr;
    logic        IC_addr_sgn;
    logic        rollback;
    logic [31:0] IC_ins;
    logic        IC_ins_sgn;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport slave (
        input  IC_addr, IC_addr_sgn, rollback, mem_rsp_valid, mem_rsp_data,
        output IC_ins, IC_ins_sgn, mem_req, mem_addr
    );

    modport master (
        output IC_addr, IC_addr_sgn, rollback, mem_rsp_valid, mem_rsp_data,
        input  IC_ins, IC_ins_sgn, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with single-word miss fills.
// Rollback suppresses the delivered word but never cancels a fill in progress.
//
// state     | meaning
// IDLE      | accepting fetch requests, hits answered next cycle
// MISS_WAIT | mem_req held, waiting for mem_rsp_valid to fill the line
module icache #(
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 32 - INDEX_W - 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {IDLE = 1'b0, MISS_WAIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [31:2]       miss_addr_q, miss_addr_d;
    logic [31:0]       ins_q, ins_d;
    logic              ins_sgn_q, ins_sgn_d;
    logic              mem_req_q, mem_req_d;
    logic              drop_q, drop_d;

    logic [INDEX_W-1:0] idx_lkp, idx_fill;
    logic               hit, req_ok, fill;

    assign idx_lkp  = bus.IC_addr[INDEX_W+1:2];
    assign idx_fill = miss_addr_q[INDEX_W+1:2];
    assign hit      = valid_q[idx_lkp] && (tag_mem[idx_lkp] == bus.IC_addr[31:INDEX_W+2]);
    assign req_ok   = bus.IC_addr_sgn && !bus.rollback;
    assign fill     = (state_q == MISS_WAIT) && bus.mem_rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_ok && !hit) state_d = MISS_WAIT;
            MISS_WAIT: if (bus.mem_rsp_valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        miss_addr_d = miss_addr_q;
        ins_d       = ins_q;
        ins_sgn_d   = 1'b0;
        mem_req_d   = mem_req_q;
        drop_d      = drop_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (hit) begin
                        ins_d     = data_mem[idx_lkp];
                        ins_sgn_d = 1'b1;
                    end else begin
                        miss_addr_d = bus.IC_addr[31:2];
                        mem_req_d   = 1'b1;
                        drop_d      = 1'b0;
                    end
                end
            end
            MISS_WAIT: begin
                // rollback in the response cycle itself must still kill delivery
                if (bus.rollback) drop_d = 1'b1;
                if (bus.mem_rsp_valid) begin
                    mem_req_d = 1'b0;
                    ins_d     = bus.mem_rsp_data;
                    ins_sgn_d = !(drop_q || bus.rollback);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            miss_addr_q <= '0;
            ins_q       <= '0;
            ins_sgn_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else if (rdy) begin
            miss_addr_q <= miss_addr_d;
            ins_q       <= ins_d;
            ins_sgn_q   <= ins_sgn_d;
            mem_req_q   <= mem_req_d;
            drop_q      <= drop_d;
            if (fill) valid_q[idx_fill] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            tag_mem[idx_fill]  <= miss_addr_q[31:INDEX_W+2];
            data_mem[idx_fill] <= bus.mem_rsp_data;
        end
    end

    assign bus.IC_ins     = ins_q;
    assign bus.IC_ins_sgn = ins_sgn_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = {miss_addr_q, 2'b00};
endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hits, conflict eviction,
// rollback, stall and asynchronous reset.
module tb_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    icache_if bus ();

    icache #(.INDEX_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.IC_addr_sgn   = 1'b0;
        bus.rollback      = 1'b0;
        bus.mem_rsp_valid = 1'b0;
    endtask

    // Issue a request that must miss, then answer it after one wait cycle.
    task automatic miss_fill(input string tag, input logic [31:0] addr, input logic [31:0] data);
        bus.IC_addr = addr; bus.IC_addr_sgn = 1'b1;
        cyc();
        bus.IC_addr_sgn = 1'b0;
        chk({tag, "_req"},  {31'd0, bus.mem_req}, 32'd1);
        chk({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_nosgn"}, {31'd0, bus.IC_ins_sgn}, 32'd0);
        cyc();
        chk({tag, "_hold"}, bus.mem_addr, {addr[31:2], 2'b00});
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = data;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        chk({tag, "_sgn"},  {31'd0, bus.IC_ins_sgn}, 32'd1);
        chk({tag, "_ins"},  bus.IC_ins, data);
        chk({tag, "_reqlo"}, {31'd0, bus.mem_req}, 32'd0);
        cyc();
        chk({tag, "_once"}, {31'd0, bus.IC_ins_sgn}, 32'd0);
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
        bus.IC_addr = addr; bus.IC_addr_sgn = 1'b1;
        cyc();
        bus.IC_addr_sgn = 1'b0;
        chk({tag, "_sgn"}, {31'd0, bus.IC_ins_sgn}, 32'd1);
        chk({tag, "_ins"}, bus.IC_ins, data);
        chk({tag, "_noreq"}, {31'd0, bus.mem_req}, 32'd0);
        cyc();
        chk({tag, "_once"}, {31'd0, bus.IC_ins_sgn}, 32'd0);
    endtask

    initial begin
        bus.IC_addr = 32'h0; bus.mem_rsp_data = 32'h0;
        idle_inputs();
        #12 rst = 1'b0;
        cyc();
        chk("rst_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("rst_sgn",  {31'd0, bus.IC_ins_sgn}, 32'd0);
        chk("rst_ins",  bus.IC_ins, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);

        // cold fetch, then hits
        miss_fill("cold", 32'h0000_0000, 32'h0000_0013);
        expect_hit("hit0", 32'h0000_0000, 32'h0000_0013);
        bus.IC_addr = 32'h0000_0002; bus.IC_addr_sgn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("b2b_sgn", {31'd0, bus.IC_ins_sgn}, 32'd1);
            chk("b2b_ins", bus.IC_ins, 32'h0000_0013);
        end
        bus.IC_addr_sgn = 1'b0;
        cyc();
        chk("b2b_end", {31'd0, bus.IC_ins_sgn}, 32'd0);

        // conflict eviction at index 0
        miss_fill("evB", 32'h0000_0200, 32'hBBBB_0001);
        miss_fill("evA", 32'h0000_0000, 32'hAAAA_0002);
        expect_hit("hitA", 32'h0000_0000, 32'hAAAA_0002);

        // request + rollback in same IDLE cycle: dropped
        bus.IC_addr = 32'h0000_0080; bus.IC_addr_sgn = 1'b1; bus.rollback = 1'b1;
        cyc();
        idle_inputs();
        chk("rbidle_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rbidle_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);

        // rollback mid-miss: fill completes, no delivery
        bus.IC_addr = 32'h0000_0040; bus.IC_addr_sgn = 1'b1;
        cyc();
        bus.IC_addr_sgn = 1'b0;
        chk("rbm_req", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        bus.rollback = 1'b1;
        cyc();
        bus.rollback = 1'b0;
        chk("rbm_hold", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hCAFE_0040;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        chk("rbm_nosgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
        chk("rbm_reqlo", {31'd0, bus.mem_req}, 32'd0);
        expect_hit("rbm_hit", 32'h0000_0040, 32'hCAFE_0040);

        // rollback coinciding with the response
        bus.IC_addr = 32'h0000_0300; bus.IC_addr_sgn = 1'b1;
        cyc();
        bus.IC_addr_sgn = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h3333_0300; bus.rollback = 1'b1;
        cyc();
        idle_inputs();
        chk("rbr_nosgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
        expect_hit("rbr_hit", 32'h0000_0300, 32'h3333_0300);

        // stall during MISS_WAIT and during a pending pulse
        bus.IC_addr = 32'h0000_0100; bus.IC_addr_sgn = 1'b1;
        cyc();
        bus.IC_addr_sgn = 1'b0;
        rdy = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stl_req", {31'd0, bus.mem_req}, 32'd1);
            chk("stl_nosgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
        end
        rdy = 1'b1; bus.mem_rsp_valid = 1'b0;
        cyc();
        chk("stl_still", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1111_0100;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        chk("stl_sgn", {31'd0, bus.IC_ins_sgn}, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stl_frz_sgn", {31'd0, bus.IC_ins_sgn}, 32'd1);
            chk("stl_frz_ins", bus.IC_ins, 32'h1111_0100);
        end
        rdy = 1'b1;
        cyc();
        chk("stl_once", {31'd0, bus.IC_ins_sgn}, 32'd0);
        expect_hit("stl_hit", 32'h0000_0100, 32'h1111_0100);

        // async reset mid-miss
        bus.IC_addr = 32'h0000_0180; bus.IC_addr_sgn = 1'b1;
        cyc();
        bus.IC_addr_sgn = 1'b0;
        chk("ar_req", {31'd0, bus.mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_async", {31'd0, bus.mem_req}, 32'd0);
        cyc();
        #2 rst = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h5555_0180;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        chk("ar_stray_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
        chk("ar_stray_req", {31'd0, bus.mem_req}, 32'd0);
        // reset invalidated everything: a previously cached line misses again
        miss_fill("ar_cold", 32'h0000_0040, 32'h7777_0040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
